// File: rtl/fifo_rr_arbiter.sv
// Round-robin write-side scheduler: grants one requester at a time onto a shared FIFO push port.
// A grant ends on end-of-burst, on the MAX_BURST-th beat, or after IDLE_TIMEOUT idle cycles.
module fifo_rr_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned IDLE_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_w_valid,
    output logic [WIDTH-1:0]           fifo_data,
    output logic                       grant_valid,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       burst_done
);

    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              burst_done_q, burst_done_d;

    logic              found;
    logic [ID_W-1:0]   pick;
    logic              g_valid;
    logic              g_last;
    logic [ID_W-1:0]   next_ptr;
    logic [WIDTH-1:0]  data_arr [N_REQ];

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_unpack
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    assign g_valid  = req_valid[grant_id_q];
    assign g_last   = req_last[grant_id_q];
    assign next_ptr = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    // First valid requester scanning upward from rr_ptr with an explicit wrap.
    always_comb begin : arb_pick
        int unsigned sum;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        pick  = '0;
        sum   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = 32'(rr_ptr_q) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = ID_W'(sum);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin : next_state
        logic rel;
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        burst_done_d = 1'b0;
        req_ready    = '0;
        fifo_w_valid = 1'b0;
        rel          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_GRANT;
                    grant_id_d = pick;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            S_GRANT: begin
                req_ready[grant_id_q] = !fifo_full;
                fifo_w_valid          = g_valid && !fifo_full;
                if (fifo_w_valid) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    idle_cnt_d = '0;
                    rel        = g_last || (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
                end else if (!g_valid) begin
                    if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        rel = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
                // A stalled valid beat holds idle_cnt, so a full FIFO never times out.
                if (rel) begin
                    state_d      = S_IDLE;
                    rr_ptr_d     = next_ptr;
                    burst_done_d = 1'b1;
                    beat_cnt_d   = '0;
                    idle_cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state_q      <= S_IDLE;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign fifo_data   = data_arr[grant_id_q];
    assign grant_valid = (state_q == S_GRANT);
    assign grant_id    = grant_id_q;
    assign burst_done  = burst_done_q;

endmodule
